period_lock_detect: RTL and testbench

Multi-channel, parametrised period-stability detector for the PLL/MMCM behavioural models. Each channel receives measured period lengths as strobed samples and reports a registered lock flag. Lock requires a run of consecutive in-tolerance matches; unlock requires a run of consecutive misses. While a channel is locked, samples are compared against a frozen reference period, so slow drift cannot keep the lock alive. The block replaces single-channel exact-match checking in the clock-generation models.

---
 rtl/period_lock_detect.sv | 151 +++++++++++++++
 tb/tb_period_lock_detect.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/period_lock_detect.sv
// Multi-channel period-stability detector: each channel locks after a run of
// in-tolerance samples and unlocks after a run of misses against a frozen reference.
module period_lock_detect #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 1,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 1,
  parameter int UNLOCK_CNT = 1
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      PWRDWN,
  input  logic [CHANNELS-1:0]       period_valid,
  input  logic [CHANNELS*WIDTH-1:0] period_length,
  output logic [CHANNELS-1:0]       period_stable,
  output logic [CHANNELS*WIDTH-1:0] period_ref,
  output logic [CHANNELS-1:0]       lock_lost,
  output logic                      all_stable
);

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED, LOSING} state_t;

  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam int UCW = $clog2(UNLOCK_CNT + 1);
  localparam logic [WIDTH-1:0] TOL_W      = WIDTH'(TOL);
  localparam logic [MCW-1:0]   LOCK_MAX   = MCW'(LOCK_CNT);
  localparam logic [UCW-1:0]   UNLOCK_MAX = UCW'(UNLOCK_CNT);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [WIDTH-1:0] last_reg, last_next;
      logic [WIDTH-1:0] ref_reg, ref_next;
      logic [MCW-1:0]   match_cnt_reg, match_cnt_next;
      logic [UCW-1:0]   miss_cnt_reg, miss_cnt_next;
      logic             stable_reg, stable_next;
      logic             lost_reg, lost_next;
      logic [WIDTH-1:0] sample, cmp, diff;
      logic             match;

      assign sample = period_length[gi*WIDTH +: WIDTH];
      // Once locked, compare against the frozen reference so drift cannot walk the lock along.
      assign cmp    = (state_reg == LOCKED || state_reg == LOSING) ? ref_reg : last_reg;
      assign diff   = (sample >= cmp) ? (sample - cmp) : (cmp - sample);
      assign match  = (sample != '0) && (cmp != '0) && (diff <= TOL_W);

      always_ff @(posedge clk or posedge RST or posedge PWRDWN) begin
        if (PWRDWN || RST) begin
          state_reg     <= UNLOCKED;
          last_reg      <= '0;
          ref_reg       <= '0;
          match_cnt_reg <= '0;
          miss_cnt_reg  <= '0;
          stable_reg    <= 1'b0;
          lost_reg      <= 1'b0;
        end else begin
          state_reg     <= state_next;
          last_reg      <= last_next;
          ref_reg       <= ref_next;
          match_cnt_reg <= match_cnt_next;
          miss_cnt_reg  <= miss_cnt_next;
          stable_reg    <= stable_next;
          lost_reg      <= lost_next;
        end
      end

      always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        ref_next       = ref_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        lost_next      = 1'b0;
        if (period_valid[gi]) begin
          case (state_reg)
            UNLOCKED: begin
              last_next = sample;
              if (match) begin
                match_cnt_next = 1'b1;
                if (LOCK_CNT == 1) begin
                  state_next    = LOCKED;
                  ref_next      = sample;
                  miss_cnt_next = '0;
                end else begin
                  state_next = LOCKING;
                end
              end else begin
                match_cnt_next = '0;
              end
            end
            LOCKING: begin
              last_next = sample;
              if (match) begin
                if (match_cnt_reg >= LOCK_MAX - 1'b1) begin
                  match_cnt_next = LOCK_MAX;
                  state_next     = LOCKED;
                  ref_next       = sample;
                  miss_cnt_next  = '0;
                end else begin
                  match_cnt_next = match_cnt_reg + 1'b1;
                end
              end else begin
                state_next     = UNLOCKED;
                match_cnt_next = '0;
              end
            end
            LOCKED: begin
              if (!match) begin
                miss_cnt_next = 1'b1;
                if (UNLOCK_CNT == 1) begin
                  state_next     = UNLOCKED;
                  lost_next      = 1'b1;
                  match_cnt_next = '0;
                  last_next      = sample;
                end else begin
                  state_next = LOSING;
                end
              end
            end
            LOSING: begin
              if (match) begin
                state_next    = LOCKED;
                ref_next      = sample;
                miss_cnt_next = '0;
              end else if (miss_cnt_reg >= UNLOCK_MAX - 1'b1) begin
                miss_cnt_next  = UNLOCK_MAX;
                state_next     = UNLOCKED;
                lost_next      = 1'b1;
                match_cnt_next = '0;
                last_next      = sample;
              end else begin
                miss_cnt_next = miss_cnt_reg + 1'b1;
              end
            end
            default: state_next = UNLOCKED;
          endcase
        end
        stable_next = (state_next == LOCKED) || (state_next == LOSING);
      end

      // The flag is deliberately undefined while powered down.
      assign period_stable[gi]              = PWRDWN ? 1'bx : stable_reg;
      assign period_ref[gi*WIDTH +: WIDTH]  = ref_reg;
      assign lock_lost[gi]                  = lost_reg;
    end
  endgenerate

  assign all_stable = &period_stable;

endmodule

// File: tb/tb_period_lock_detect.sv
// Directed bench for period_lock_detect: a main 2-channel instance and a legacy
// single-channel instance, checked every cycle against a behavioural model.
module tb_period_lock_detect;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        PWRDWN = 1'b0;

  logic [1:0]  a_valid = '0;
  logic [63:0] a_len = '0;
  logic [1:0]  a_stable;
  logic [63:0] a_ref;
  logic [1:0]  a_lost;
  logic        a_all;

  logic [0:0]  b_valid = '0;
  logic [31:0] b_len = '0;
  logic [0:0]  b_stable;
  logic [31:0] b_ref;
  logic [0:0]  b_lost;
  logic        b_all;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  period_lock_detect #(.WIDTH(32), .CHANNELS(2), .TOL(2), .LOCK_CNT(3), .UNLOCK_CNT(2)) u_main (
    .clk(clk), .RST(RST), .PWRDWN(PWRDWN),
    .period_valid(a_valid), .period_length(a_len),
    .period_stable(a_stable), .period_ref(a_ref), .lock_lost(a_lost), .all_stable(a_all)
  );

  period_lock_detect #(.WIDTH(32), .CHANNELS(1), .TOL(0), .LOCK_CNT(1), .UNLOCK_CNT(1)) u_legacy (
    .clk(clk), .RST(RST), .PWRDWN(PWRDWN),
    .period_valid(b_valid), .period_length(b_len),
    .period_stable(b_stable), .period_ref(b_ref), .lock_lost(b_lost), .all_stable(b_all)
  );

  // Model slots: 0/1 = main channels, 2 = legacy channel
  int          m_tol[3] = '{2, 2, 0};
  int          m_lk[3]  = '{3, 3, 1};
  int          m_ul[3]  = '{2, 2, 1};
  bit          m_locked[3];
  int unsigned m_last[3];
  int unsigned m_ref[3];
  int          m_run[3];
  int          m_miss[3];
  bit          m_lost[3];

  task automatic step(input int k, input int unsigned s);
    longint c, d;
    bit hit;
    c = m_locked[k] ? longint'(m_ref[k]) : longint'(m_last[k]);
    d = longint'(s) - c;
    if (d < 0) d = -d;
    hit = (s != 0) && (c != 0) && (d <= longint'(m_tol[k]));
    if (!m_locked[k]) begin
      m_last[k] = s;
      if (hit) begin
        m_run[k]++;
        if (m_run[k] >= m_lk[k]) begin
          m_locked[k] = 1'b1;
          m_ref[k]    = s;
          m_miss[k]   = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end else if (hit) begin
      if (m_miss[k] > 0) m_ref[k] = s;
      m_miss[k] = 0;
    end else begin
      m_miss[k]++;
      if (m_miss[k] >= m_ul[k]) begin
        m_locked[k] = 1'b0;
        m_lost[k]   = 1'b1;
        m_run[k]    = 0;
        m_last[k]   = s;
      end
    end
  endtask

  always @(posedge clk or posedge RST or posedge PWRDWN) begin
    if (RST || PWRDWN) begin
      for (int k = 0; k < 3; k++) begin
        m_locked[k] = 1'b0; m_last[k] = 0; m_ref[k] = 0;
        m_run[k] = 0; m_miss[k] = 0; m_lost[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) m_lost[k] = 1'b0;
      if (a_valid[0]) step(0, a_len[31:0]);
      if (a_valid[1]) step(1, a_len[63:32]);
      if (b_valid[0]) step(2, b_len);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        if (!PWRDWN) chk($sformatf("main_stable[%0d]", k), 64'(a_stable[k]), 64'(m_locked[k]));
        chk($sformatf("main_ref[%0d]", k), 64'(a_ref[k*32 +: 32]), 64'(m_ref[k]));
        chk($sformatf("main_lost[%0d]", k), 64'(a_lost[k]), 64'(m_lost[k]));
      end
      if (!PWRDWN) begin
        chk("main_all", 64'(a_all), 64'(m_locked[0] & m_locked[1]));
        chk("leg_stable", 64'(b_stable), 64'(m_locked[2]));
      end
      chk("leg_ref", 64'(b_ref), 64'(m_ref[2]));
      chk("leg_lost", 64'(b_lost), 64'(m_lost[2]));
    end
  end

  task automatic sa(input logic [1:0] v, input logic [31:0] s0, input logic [31:0] s1);
    a_valid = v;
    a_len   = {s1, s0};
    @(negedge clk);
    a_valid = '0;
  endtask

  task automatic sb(input logic [31:0] s);
    b_valid = 1'b1;
    b_len   = s;
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    RST = 1'b0;
    chk_en = 1'b1;

    // Lock acquisition on ch0
    sa(2'b01, 100, 0);
    sa(2'b01, 101, 0);
    sa(2'b01, 99, 0);
    chk("acq_before_4th", 64'(a_stable), 64'd0);
    sa(2'b01, 100, 0);
    chk("acq_stable", 64'(a_stable), 64'b01);
    chk("acq_ref0", 64'(a_ref[31:0]), 64'd100);
    chk("acq_all", 64'(a_all), 64'd0);

    // Hysteresis
    sa(2'b01, 110, 0);
    chk("hys_losing", 64'(a_stable[0]), 64'd1);
    sa(2'b01, 100, 0);
    sa(2'b01, 110, 0);
    chk("hys_losing2", 64'(a_stable[0]), 64'd1);
    sa(2'b01, 0, 0);
    chk("hys_drop", 64'(a_stable[0]), 64'd0);
    chk("hys_lost_pulse", 64'(a_lost), 64'b01);
    @(negedge clk);
    chk("hys_lost_end", 64'(a_lost), 64'd0);
    chk("hys_ref_hold", 64'(a_ref[31:0]), 64'd100);

    // Drift rejection
    repeat (4) sa(2'b01, 100, 0);
    chk("drift_locked", 64'(a_stable[0]), 64'd1);
    sa(2'b01, 102, 0);
    sa(2'b01, 104, 0);
    chk("drift_104", 64'(a_stable[0]), 64'd1);
    sa(2'b01, 106, 0);
    chk("drift_unlock", 64'(a_stable[0]), 64'd0);
    chk("drift_lost", 64'(a_lost), 64'b01);

    // Parallel lock
    repeat (4) sa(2'b11, 200, 300);
    chk("par_all", 64'(a_all), 64'd1);
    chk("par_ref1", 64'(a_ref[63:32]), 64'd300);

    // Power-down mid-cycle
    #2 PWRDWN = 1'b1;
    #1 chk("pd_lost", 64'(a_lost), 64'd0);
    chk("pd_ref", 64'(a_ref), 64'd0);
    repeat (2) @(negedge clk);
    PWRDWN = 1'b0;
    #1 chk("pd_release", 64'(a_stable), 64'd0);
    @(negedge clk);
    repeat (3) sa(2'b11, 200, 300);
    chk("pd_three", 64'(a_stable), 64'd0);
    sa(2'b11, 200, 300);
    chk("pd_relock", 64'(a_stable), 64'b11);

    // Asynchronous reset while locked
    #2 RST = 1'b1;
    #1 chk("rst_stable", 64'(a_stable), 64'd0);
    chk("rst_ref", 64'(a_ref), 64'd0);
    chk("rst_lost", 64'(a_lost), 64'd0);
    chk("rst_all", 64'(a_all), 64'd0);
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);

    // Reset mid-LOCKING
    repeat (3) sa(2'b01, 500, 0);
    #2 RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    repeat (3) sa(2'b01, 500, 0);
    chk("rst_lock_three", 64'(a_stable[0]), 64'd0);
    sa(2'b01, 500, 0);
    chk("rst_lock_four", 64'(a_stable[0]), 64'd1);
    chk("rst_lock_ref", 64'(a_ref[31:0]), 64'd500);

    // Tolerance edge: steps of 3 never lock ch1
    sa(2'b10, 0, 400);
    sa(2'b10, 0, 403);
    sa(2'b10, 0, 406);
    sa(2'b10, 0, 409);
    chk("tol_over", 64'(a_stable[1]), 64'd0);

    // Legacy configuration
    sb(50);
    chk("leg_first", 64'(b_stable), 64'd0);
    sb(50);
    chk("leg_lock", 64'(b_stable), 64'd1);
    chk("leg_ref50", 64'(b_ref), 64'd50);
    sb(51);
    chk("leg_drop", 64'(b_stable), 64'd0);
    chk("leg_pulse", 64'(b_lost), 64'd1);
    @(negedge clk);
    chk("leg_pulse_end", 64'(b_lost), 64'd0);
    sb(0);
    sb(0);
    chk("leg_zero", 64'(b_stable), 64'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
